// File: rtl/npu_host_seq.sv
// npu_host_seq: host-side initiator that loads weights and image columns into the NPU,
// polls pixel_valid and collects results in a small FIFO. Optional poll timeout: NPU_HOST_TIMEOUT_EN.
module npu_host_seq #(
  parameter int unsigned K_W        = 3,
  parameter int unsigned OUT_H      = 14,
  parameter int unsigned OUT_W      = 13,
  parameter int unsigned SRC_AW     = 16,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned POLL_MAX   = 255
) (
  input  logic              clk,
  input  logic              rst_ni,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [SRC_AW-1:0] src_addr,
  input  logic [23:0]       src_data,
  output logic              ena,
  output logic              wea,
  output logic [15:0]       addra,
  output logic [31:0]       dina,
  input  logic [31:0]       douta,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [23:0]       res_data
);

  localparam int unsigned IN_W = OUT_W + K_W - 1;
  localparam int unsigned JW   = (K_W > 1) ? $clog2(K_W) : 1;
  localparam int unsigned CW   = (OUT_W > 1) ? $clog2(OUT_W) : 1;
  localparam int unsigned RW   = (OUT_H > 1) ? $clog2(OUT_H) : 1;
  localparam int unsigned PW   = $clog2(FIFO_DEPTH);
  localparam int unsigned NW   = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [3:0] {
    S_IDLE, S_W_FETCH, S_W_WRITE, S_I_FETCH, S_I_WRITE,
    S_POLL_RD, S_POLL_CHK, S_RES_RD, S_RES_CAP, S_FINISH
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [JW-1:0]     r_j, w_j_nxt;
  logic [CW-1:0]     r_c, w_c_nxt, w_c_adv;
  logic [RW-1:0]     r_r, w_r_nxt, w_r_adv;
  logic              r_err, w_err_nxt;
  logic              r_pv_seen, w_pv_seen_nxt;
  logic              r_busy, r_done, r_ena, r_wea, r_wr_pass;
  logic [15:0]       r_addra, w_addra_nxt;
  logic [31:0]       r_dina;
  logic [SRC_AW-1:0] r_src_addr, w_src_addr_nxt;
  logic              w_ena_nxt, w_wea_nxt;
  logic              w_row_end, w_last_pix;
  logic              w_push, w_pop, w_full;
  logic [23:0]       r_mem [FIFO_DEPTH];
  logic [PW-1:0]     r_wr_ptr, r_rd_ptr;
  logic [NW-1:0]     r_cnt, w_cnt_nxt;
  logic              r_res_valid;
  logic              w_unused;

`ifdef NPU_HOST_TIMEOUT_EN
  localparam int unsigned PCW = $clog2(POLL_MAX + 1);
  logic [PCW-1:0] r_poll_cnt, w_poll_cnt_nxt;
  assign w_unused = ^douta[31:24];
`else
  assign w_unused = ^{douta[31:24], 32'(POLL_MAX)};
`endif

  // Pixel advance: column wraps at the row end, the row then increments
  assign w_row_end  = (r_c == CW'(OUT_W - 1));
  assign w_last_pix = w_row_end && (r_r == RW'(OUT_H - 1));
  assign w_c_adv    = w_row_end ? '0 : r_c + CW'(1);
  assign w_r_adv    = w_row_end ? r_r + RW'(1) : r_r;
  assign w_full     = (r_cnt == NW'(FIFO_DEPTH));

  always_comb begin
    w_state_nxt   = r_state;
    w_j_nxt       = r_j;
    w_c_nxt       = r_c;
    w_r_nxt       = r_r;
    w_err_nxt     = r_err;
    w_pv_seen_nxt = r_pv_seen;
    w_push        = 1'b0;
`ifdef NPU_HOST_TIMEOUT_EN
    w_poll_cnt_nxt = r_poll_cnt;
`endif
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_err_nxt     = 1'b0;
          w_j_nxt       = '0;
          w_c_nxt       = '0;
          w_r_nxt       = '0;
          w_pv_seen_nxt = 1'b0;
          w_state_nxt   = S_W_FETCH;
        end
      end
      S_W_FETCH: w_state_nxt = S_W_WRITE;
      S_W_WRITE: begin
        if (r_j < JW'(K_W - 1)) begin
          w_j_nxt     = r_j + JW'(1);
          w_state_nxt = S_W_FETCH;
        end else begin
          w_j_nxt     = '0;
          w_state_nxt = S_I_FETCH;
        end
      end
      S_I_FETCH: w_state_nxt = S_I_WRITE;
      S_I_WRITE: begin
        if (r_j < JW'(K_W - 1)) begin
          w_j_nxt     = r_j + JW'(1);
          w_state_nxt = S_I_FETCH;
        end else begin
          w_j_nxt     = '0;
          w_state_nxt = S_POLL_RD;
`ifdef NPU_HOST_TIMEOUT_EN
          w_poll_cnt_nxt = '0;
`endif
        end
      end
      S_POLL_RD: w_state_nxt = S_POLL_CHK;
      S_POLL_CHK: begin
        // A seen pixel_valid is remembered while the FIFO is full
        if (douta[0] || r_pv_seen) begin
          if (!w_full) begin
            w_pv_seen_nxt = 1'b0;
            w_state_nxt   = S_RES_RD;
          end else begin
            w_pv_seen_nxt = 1'b1;
          end
        end else begin
`ifdef NPU_HOST_TIMEOUT_EN
          if (r_poll_cnt == PCW'(POLL_MAX - 1)) begin
            w_err_nxt   = 1'b1;
            w_c_nxt     = w_c_adv;
            w_r_nxt     = w_r_adv;
            w_state_nxt = w_last_pix ? S_FINISH : S_I_FETCH;
          end else begin
            w_poll_cnt_nxt = r_poll_cnt + PCW'(1);
            w_state_nxt    = S_POLL_RD;
          end
`else
          w_state_nxt = S_POLL_RD;
`endif
        end
      end
      S_RES_RD: w_state_nxt = S_RES_CAP;
      S_RES_CAP: begin
        w_push      = 1'b1;
        w_c_nxt     = w_c_adv;
        w_r_nxt     = w_r_adv;
        w_state_nxt = w_last_pix ? S_FINISH : S_I_FETCH;
      end
      S_FINISH: w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // Bus outputs are decoded from the next state so they register in step with it
  always_comb begin
    w_ena_nxt      = 1'b0;
    w_wea_nxt      = 1'b0;
    w_addra_nxt    = 16'd0;
    w_src_addr_nxt = r_src_addr;
    case (w_state_nxt)
      S_W_FETCH: w_src_addr_nxt = SRC_AW'(w_j_nxt);
      S_I_FETCH: w_src_addr_nxt = SRC_AW'(K_W) + SRC_AW'(w_r_nxt) * SRC_AW'(IN_W)
                                  + SRC_AW'(w_c_nxt) + SRC_AW'(w_j_nxt);
      S_W_WRITE: begin
        w_ena_nxt   = 1'b1;
        w_wea_nxt   = 1'b1;
        w_addra_nxt = 16'd2;
      end
      S_I_WRITE: begin
        w_ena_nxt   = 1'b1;
        w_wea_nxt   = 1'b1;
        w_addra_nxt = 16'd1;
      end
      S_POLL_RD: begin
        w_ena_nxt   = 1'b1;
        w_addra_nxt = 16'd3;
      end
      S_RES_RD: begin
        w_ena_nxt   = 1'b1;
        w_addra_nxt = 16'd2;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state    <= S_IDLE;
      r_j        <= '0;
      r_c        <= '0;
      r_r        <= '0;
      r_err      <= 1'b0;
      r_pv_seen  <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_ena      <= 1'b0;
      r_wea      <= 1'b0;
      r_wr_pass  <= 1'b0;
      r_addra    <= 16'd0;
      r_dina     <= 32'd0;
      r_src_addr <= '0;
`ifdef NPU_HOST_TIMEOUT_EN
      r_poll_cnt <= '0;
`endif
    end else begin
      r_state    <= w_state_nxt;
      r_j        <= w_j_nxt;
      r_c        <= w_c_nxt;
      r_r        <= w_r_nxt;
      r_err      <= w_err_nxt;
      r_pv_seen  <= w_pv_seen_nxt;
      r_busy     <= (w_state_nxt != S_IDLE) && (w_state_nxt != S_FINISH);
      r_done     <= (w_state_nxt == S_FINISH);
      r_ena      <= w_ena_nxt;
      r_wea      <= w_wea_nxt;
      r_wr_pass  <= w_wea_nxt;
      r_addra    <= w_addra_nxt;
      r_src_addr <= w_src_addr_nxt;
      if (r_wr_pass) r_dina <= {8'h00, src_data};
`ifdef NPU_HOST_TIMEOUT_EN
      r_poll_cnt <= w_poll_cnt_nxt;
`endif
    end
  end

  // Result FIFO; simultaneous push and pop keep the count unchanged
  assign w_pop = res_ready && (r_cnt != '0);

  always_comb begin
    w_cnt_nxt = r_cnt;
    if (w_push && !w_pop)      w_cnt_nxt = r_cnt + NW'(1);
    else if (!w_push && w_pop) w_cnt_nxt = r_cnt - NW'(1);
  end

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) r_mem[i] <= 24'd0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_cnt       <= '0;
      r_res_valid <= 1'b0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= douta[23:0];
        r_wr_ptr        <= r_wr_ptr + PW'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + PW'(1);
      r_cnt       <= w_cnt_nxt;
      r_res_valid <= (w_cnt_nxt != '0);
    end
  end

  // Source data feeds dina directly during a write cycle, then the register holds it
  assign dina      = r_wr_pass ? {8'h00, src_data} : r_dina;
  assign busy      = r_busy;
  assign done      = r_done;
  assign err       = r_err;
  assign ena       = r_ena;
  assign wea       = r_wea;
  assign addra     = r_addra;
  assign src_addr  = r_src_addr;
  assign res_valid = r_res_valid;
  assign res_data  = r_mem[r_rd_ptr];

endmodule

// File: tb/tb_npu_host_seq.sv
// tb_npu_host_seq: directed bench for npu_host_seq with a source-memory and NPU port model.
// Exercises the timeout scenario when NPU_HOST_TIMEOUT_EN is defined.
module tb_npu_host_seq;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic        start = 1'b0;
  logic        busy, done, err;
  logic [15:0] src_addr;
  logic [23:0] src_data = 24'd0;
  logic        ena, wea;
  logic [15:0] addra;
  logic [31:0] dina;
  logic [31:0] douta = 32'd0;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [23:0] res_data;

  int          n_chk = 0;
  int          n_fail = 0;
  int unsigned cfg_first = 0;
  int unsigned m_zero = 0;
  int unsigned m_idx = 0;

  npu_host_seq #(.K_W(3), .OUT_H(14), .OUT_W(13), .SRC_AW(16), .FIFO_DEPTH(4), .POLL_MAX(8)) dut (
    .clk(clk), .rst_ni(rst_ni), .start(start), .busy(busy), .done(done), .err(err),
    .src_addr(src_addr), .src_data(src_data), .ena(ena), .wea(wea), .addra(addra),
    .dina(dina), .douta(douta), .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data)
  );

  always #5 clk = ~clk;

  function automatic logic [23:0] src_word(input int unsigned a);
    case (a)
      0: return 24'h030201;
      1: return 24'h060504;
      2: return 24'h090807;
      default: return {a[7:0] ^ 8'h5A, 8'(a >> 3), 8'(a * 7)};
    endcase
  endfunction

  // Source memory: one-cycle read latency
  always @(posedge clk) src_data <= src_word(32'(src_addr));

  // NPU model: first cfg_first polls of a pass return 0, results count up from 0
  always @(posedge clk) begin
    if (start) begin
      m_zero <= cfg_first;
      m_idx  <= 0;
    end else if (ena && !wea) begin
      case (addra)
        16'd3: begin
          douta <= {31'd0, m_zero == 0};
          if (m_zero != 0) m_zero <= m_zero - 1;
        end
        16'd2: begin
          douta <= {8'hA5, m_idx[23:0]};
          m_idx <= m_idx + 1;
        end
        default: douta <= 32'd0;
      endcase
    end
  end

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    repeat (2) @(negedge clk);
    n_chk++;
    if ({busy, done, err} !== 3'b000) begin
      $display("FAIL reset_ctrl got=%b exp=000", {busy, done, err}); n_fail++;
    end
    n_chk++;
    if ({ena, wea, addra, dina} !== 50'd0) begin
      $display("FAIL reset_bus got=%h exp=0", {ena, wea, addra, dina}); n_fail++;
    end
    n_chk++;
    if (src_addr !== 16'd0) begin
      $display("FAIL reset_src_addr got=%h exp=0", src_addr); n_fail++;
    end
    n_chk++;
    if ({res_valid, res_data} !== 25'd0) begin
      $display("FAIL reset_fifo got=%h exp=0", {res_valid, res_data}); n_fail++;
    end
    rst_ni = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_weight_load();
    res_ready = 1'b1; cfg_first = 0;
    pulse_start();
    n_chk++;
    if (busy !== 1'b1) begin $display("FAIL wl_busy got=%b exp=1", busy); n_fail++; end
    for (int k = 0; k < 3; k++) begin
      n_chk++;
      if ({ena, src_addr} !== {1'b0, 16'(k)}) begin
        $display("FAIL wl_fetch%0d got=%h exp=%h", k, {ena, src_addr}, {1'b0, 16'(k)}); n_fail++;
      end
      @(negedge clk);
      n_chk++;
      if ({ena, wea, addra, dina} !== {2'b11, 16'd2, 8'h00, src_word(k)}) begin
        $display("FAIL wl_write%0d got=%h exp=%h", k, {ena, wea, addra, dina}, {2'b11, 16'd2, 8'h00, src_word(k)});
        n_fail++;
      end
      @(negedge clk);
    end
    for (int k = 0; k < 3; k++) begin
      n_chk++;
      if ({ena, src_addr} !== {1'b0, 16'(3 + k)}) begin
        $display("FAIL img_fetch%0d got=%h exp=%h", k, {ena, src_addr}, {1'b0, 16'(3 + k)}); n_fail++;
      end
      @(negedge clk);
      n_chk++;
      if ({ena, wea, addra, dina} !== {2'b11, 16'd1, 8'h00, src_word(3 + k)}) begin
        $display("FAIL img_write%0d got=%h exp=%h", k, {ena, wea, addra, dina}, {2'b11, 16'd1, 8'h00, src_word(3 + k)});
        n_fail++;
      end
      @(negedge clk);
    end
    n_chk++;
    if ({ena, wea, addra} !== {2'b10, 16'd3}) begin
      $display("FAIL poll_rd got=%h exp=%h", {ena, wea, addra}, {2'b10, 16'd3}); n_fail++;
    end
    @(negedge clk);
    n_chk++;
    if (ena !== 1'b0) begin $display("FAIL poll_chk_ena got=%b exp=0", ena); n_fail++; end
    @(negedge clk);
    n_chk++;
    if ({ena, wea, addra} !== {2'b10, 16'd2}) begin
      $display("FAIL res_rd got=%h exp=%h", {ena, wea, addra}, {2'b10, 16'd2}); n_fail++;
    end
    @(negedge clk);
    n_chk++;
    if ({ena, res_valid} !== 2'b00) begin
      $display("FAIL res_cap got=%b exp=00", {ena, res_valid}); n_fail++;
    end
    @(negedge clk);
    n_chk++;
    if ({res_valid, res_data, src_addr} !== {1'b1, 24'd0, 16'd4}) begin
      $display("FAIL first_result got=%h exp=%h", {res_valid, res_data, src_addr}, {1'b1, 24'd0, 16'd4});
      n_fail++;
    end
  endtask

  task automatic test_reset_mid_pass();
    int act = 0;
    @(negedge clk);
    n_chk++;
    if ({ena, wea, addra} !== {2'b11, 16'd1}) begin
      $display("FAIL mid_pre_iwrite got=%h exp=%h", {ena, wea, addra}, {2'b11, 16'd1}); n_fail++;
    end
    rst_ni = 1'b0;
    #1;
    n_chk++;
    if ({busy, done, err, ena, wea, addra, dina, src_addr, res_valid, res_data} !== 95'd0) begin
      $display("FAIL mid_reset_outputs got=%h exp=0",
               {busy, done, err, ena, wea, addra, dina, src_addr, res_valid, res_data});
      n_fail++;
    end
    repeat (2) @(negedge clk);
    rst_ni = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (ena || busy) act++;
    end
    n_chk++;
    if (act !== 0) begin $display("FAIL mid_reset_idle active_cycles=%0d exp=0", act); n_fail++; end
  endtask

  task automatic test_full_pass();
    int exp_idx = 0;
    int dones = 0;
    int tail = -1;
    res_ready = 1'b1; cfg_first = 0;
    pulse_start();
    for (int cyc = 0; cyc < 4000 && tail != 0; cyc++) begin
      start = 1'b0;
      if (res_valid && res_ready) begin
        n_chk++;
        if (res_data !== 24'(exp_idx)) begin
          $display("FAIL full_data idx=%0d got=%0d exp=%0d", exp_idx, res_data, exp_idx); n_fail++;
        end
        exp_idx++;
      end
      if (done) begin
        dones++;
        if (tail < 0) begin tail = 6; start = 1'b1; end
      end
      if (tail > 0) tail--;
      @(negedge clk);
    end
    start = 1'b0;
    n_chk++;
    if (tail !== 0) begin $display("FAIL full_timeout done not seen got=%0d exp=0", tail); n_fail++; end
    n_chk++;
    if (exp_idx !== 182) begin $display("FAIL full_count got=%0d exp=182", exp_idx); n_fail++; end
    n_chk++;
    if (dones !== 1) begin $display("FAIL full_done_pulses got=%0d exp=1", dones); n_fail++; end
    n_chk++;
    if ({busy, ena, res_valid} !== 3'b000) begin
      $display("FAIL full_after got=%b exp=000", {busy, ena, res_valid}); n_fail++;
    end
  endtask

  task automatic test_backpressure();
    int exp_idx = 0;
    int dones = 0;
    int tail = -1;
    int act = 0;
    res_ready = 1'b0; cfg_first = 0;
    pulse_start();
    repeat (80) @(negedge clk);
    n_chk++;
    if ({busy, res_valid, res_data} !== {2'b11, 24'd0}) begin
      $display("FAIL bp_hold got=%h exp=%h", {busy, res_valid, res_data}, {2'b11, 24'd0}); n_fail++;
    end
    for (int i = 0; i < 20; i++) begin
      if (ena) act++;
      @(negedge clk);
    end
    n_chk++;
    if (act !== 0) begin $display("FAIL bp_no_bus got=%0d exp=0", act); n_fail++; end
    res_ready = 1'b1;
    for (int cyc = 0; cyc < 4000 && tail != 0; cyc++) begin
      if (res_valid && res_ready) begin
        n_chk++;
        if (res_data !== 24'(exp_idx)) begin
          $display("FAIL bp_data idx=%0d got=%0d exp=%0d", exp_idx, res_data, exp_idx); n_fail++;
        end
        exp_idx++;
      end
      if (done) begin dones++; if (tail < 0) tail = 6; end
      if (tail > 0) tail--;
      @(negedge clk);
    end
    n_chk++;
    if (exp_idx !== 182) begin $display("FAIL bp_count got=%0d exp=182", exp_idx); n_fail++; end
    n_chk++;
    if (dones !== 1) begin $display("FAIL bp_done_pulses got=%0d exp=1", dones); n_fail++; end
  endtask

  task automatic test_slow_npu();
    int polls = 0;
    int rds = 0;
    bit fin = 1'b0;
    res_ready = 1'b1; cfg_first = 5;
    pulse_start();
    for (int cyc = 0; cyc < 300 && !fin; cyc++) begin
      if (ena && !wea && addra == 16'd3) polls++;
      if (ena && !wea && addra == 16'd2) rds++;
      if (ena && wea && addra == 16'd1 && rds > 0) fin = 1'b1;
      else @(negedge clk);
    end
    n_chk++;
    if (fin !== 1'b1) begin $display("FAIL slow_timeout got=%b exp=1", fin); n_fail++; end
    n_chk++;
    if (polls !== 6) begin $display("FAIL slow_polls got=%0d exp=6", polls); n_fail++; end
    n_chk++;
    if (rds !== 1) begin $display("FAIL slow_res_reads got=%0d exp=1", rds); n_fail++; end
    rst_ni = 1'b0;
    repeat (2) @(negedge clk);
    rst_ni = 1'b1;
    @(negedge clk);
  endtask

`ifdef NPU_HOST_TIMEOUT_EN
  task automatic test_timeout();
    int polls = 0;
    int exp_idx = 0;
    int tail = -1;
    res_ready = 1'b1; cfg_first = 8;
    pulse_start();
    for (int cyc = 0; cyc < 300 && !err; cyc++) begin
      if (ena && !wea && addra == 16'd3) polls++;
      @(negedge clk);
    end
    n_chk++;
    if (err !== 1'b1) begin $display("FAIL to_err got=%b exp=1", err); n_fail++; end
    n_chk++;
    if (polls !== 8) begin $display("FAIL to_polls got=%0d exp=8", polls); n_fail++; end
    n_chk++;
    if (src_addr !== 16'd4) begin $display("FAIL to_next_pixel got=%0d exp=4", src_addr); n_fail++; end
    for (int cyc = 0; cyc < 4000 && tail != 0; cyc++) begin
      if (res_valid && res_ready) begin
        n_chk++;
        if (res_data !== 24'(exp_idx)) begin
          $display("FAIL to_data idx=%0d got=%0d exp=%0d", exp_idx, res_data, exp_idx); n_fail++;
        end
        exp_idx++;
      end
      if (done && tail < 0) tail = 6;
      if (tail > 0) tail--;
      @(negedge clk);
    end
    n_chk++;
    if (exp_idx !== 181) begin $display("FAIL to_count got=%0d exp=181", exp_idx); n_fail++; end
    cfg_first = 0;
    pulse_start();
    n_chk++;
    if ({busy, err} !== 2'b10) begin $display("FAIL to_err_clear got=%b exp=10", {busy, err}); n_fail++; end
    rst_ni = 1'b0;
    repeat (2) @(negedge clk);
    rst_ni = 1'b1;
    @(negedge clk);
  endtask
`else
  task automatic test_no_timeout();
    int rds = 0;
    res_ready = 1'b1; cfg_first = 1000000;
    pulse_start();
    for (int i = 0; i < 120; i++) begin
      if (ena && !wea && addra == 16'd2) rds++;
      @(negedge clk);
    end
    n_chk++;
    if ({busy, err} !== 2'b10) begin $display("FAIL nto_state got=%b exp=10", {busy, err}); n_fail++; end
    n_chk++;
    if (rds !== 0) begin $display("FAIL nto_res_reads got=%0d exp=0", rds); n_fail++; end
    rst_ni = 1'b0;
    repeat (2) @(negedge clk);
    rst_ni = 1'b1;
    @(negedge clk);
  endtask
`endif

  initial begin
    test_reset();
    test_weight_load();
    test_reset_mid_pass();
    test_full_pass();
    test_backpressure();
    test_slow_npu();
`ifdef NPU_HOST_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/npu_host_seq.md
# npu_host_seq

Host-side initiator for the NPU's single-port memory-mapped control interface (`ena`/`wea`/`addra`/`dina`/`douta`). On `start` it fetches the conv weight columns and image columns from a packed source memory, writes them into the NPU, polls the pixel-valid flag, and reads each result. Results are pushed into an internal result FIFO with a valid/ready output. It replaces the CPU as the driver of the NPU's convolution pass in standalone and test builds.

## Interface
- `K_W`, 3, kernel width; number of column writes per pixel and per weight load.
- `OUT_H`, 14, output rows.
- `OUT_W`, 13, output columns; image width `IN_W = OUT_W+K_W-1`.
- `SRC_AW`, 16, source address width.
- `FIFO_DEPTH`, 4, result FIFO entries; power of two, at least 2.
- `POLL_MAX`, 255, poll reads before timeout; used only when `NPU_HOST_TIMEOUT_EN` is defined.
- `clk`  in  1  clock; single clock domain.
- `rst_ni`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle pulse; ignored while `busy`.
- `busy`  out  1  high from the cycle after an accepted `start` until FINISH.
- `done`  out  1  one-cycle pulse when the full pass completes.
- `err`  out  1  sticky timeout flag; cleared by the next accepted `start`.
- `src_addr`  out  SRC_AW  source read address.
- `src_data`  in  24  source data, valid one cycle after `src_addr`; bytes are rows 0/1/2.
- `ena`, `wea`  out  1  NPU port enable and write enable.
- `addra`  out  16  NPU address; only [2:0] non-zero.
- `dina`  out  32  NPU write data `{8'h00, src_data}`.
- `douta`  in  32  NPU read data; registered by the NPU, so it is sampled the cycle after a read.
- `res_valid`  out  1  result FIFO not empty.
- `res_ready`  in  1  consumer accepts.
- `res_data`  out  24  FIFO head: NPU result `douta[23:0]`.

## Operation
- NPU address selects: 001 = image column write; 010 = weight column write; read 1 = done; read 2 = result; read 3 = pixel_valid.
- Source layout:
  - weight column j at address j;
  - image column for output row r and input column x at address `K_W + r*IN_W + x`.
- States:
  - IDLE: waits for `start`. On `start`, clears `err`, resets the row, column and column-index counters, and goes to W_FETCH.
  - W_FETCH: drives `src_addr = j`; goes to W_WRITE.
  - W_WRITE: drives `ena=wea=1`, `addra=2`, `dina={8'h00,src_data}`. If `j < K_W-1`, increments `j` and returns to W_FETCH; otherwise clears `j` and goes to I_FETCH.
  - I_FETCH: drives `src_addr = K_W + r*IN_W + c + j`; goes to I_WRITE.
  - I_WRITE: same as W_WRITE but with `addra=1`. After the last column it goes to POLL_RD.
  - POLL_RD: drives `ena=1`, `wea=0`, `addra=3`; goes to POLL_CHK.
  - POLL_CHK: if `douta[0]`, goes to RES_RD; else returns to POLL_RD.
  - RES_RD: entered only when the FIFO is not full; otherwise the FSM holds in POLL_CHK with no bus activity. Drives a read with `addra=2`; goes to RES_CAP.
  - RES_CAP: pushes `douta[23:0]`, then advances `c`. When `c` reaches `OUT_W-1` it wraps to 0 and `r` increments. If more pixels remain, goes to I_FETCH; after the last pixel goes to FINISH.
  - FINISH: pulses `done`, deasserts `busy`, returns to IDLE.
- Weights are loaded once per pass; the NPU's circular weight register performs the rotation.
- Outside write and read states, `ena=wea=0`, `addra=0` and `dina` holds its value.
- Result FIFO:
  - push and pop in the same cycle are both allowed;
  - a pop from an empty FIFO has no effect;
  - a push when full cannot occur because of the RES_RD gating;
  - contents are discarded on reset and not cleared by `start`.

## Timing
- Reset values: `busy=0`, `done=0`, `err=0`, `ena=0`, `wea=0`, `addra=0`, `dina=0`, `src_addr=0`, `res_valid=0`, `res_data=0`, FSM in IDLE.
- Asserting reset mid-pass aborts immediately; no further NPU accesses occur.
- `start` is accepted at cycle t. W_FETCH occurs at t+1, and the first weight write is on the bus at t+2.
- Each column costs 2 cycles. The weight phase takes `2*K_W` cycles.
- Per pixel, the best case is `2*K_W + 4` cycles: image columns, one poll pair, one result pair.
- `res_valid` rises the cycle after RES_CAP.
- `start` arriving in the same cycle as FINISH is ignored.

## Configuration
- `NPU_HOST_TIMEOUT_EN` defined: a poll counter resets on entering POLL_RD from I_WRITE and increments each time POLL_CHK sees 0. When it reaches `POLL_MAX`, the FSM sets `err`, skips the pixel without pushing, and continues to the next pixel.
- Not defined: no counter, `err` is tied to 0, and the FSM polls indefinitely.

## Test plan
- Reset mid-pass: assert `rst_ni=0` during I_WRITE. All outputs take their reset values within the same cycle, and the FSM is in IDLE after release.
- Weight load: source words 0..2 = 0x030201, 0x060504, 0x090807 → three writes with `addra=2` and `dina` = 0x00030201, 0x00060504, 0x00090807 on consecutive even cycles.
- Full pass with an NPU model that returns valid on the first poll and result = pixel index → 182 FIFO entries 0..181 in order; `done` pulses once; `busy` is low afterward.
- Backpressure: hold `res_ready=0`. After 4 results the FSM holds in POLL_CHK with `ena=0`. Releasing `res_ready` resumes with no lost or duplicated results.
- Slow NPU: pixel_valid is delayed by 5 polls → exactly 6 reads with `addra=3`, then one read with `addra=2`.
- Timeout (with `NPU_HOST_TIMEOUT_EN`, `POLL_MAX=8`): pixel_valid is stuck at 0 for pixel 0 → `err=1` after 8 polls; pixel 0 is skipped and pixel 1 proceeds; the next `start` clears `err`.
